// File: rtl/threshold_window_integrator.sv
`default_nettype none
// ============================================================================
// Module   : threshold_window_integrator
// Purpose  : Per-channel sliding-window integrator over offset-binary samples.
//            Raises a sticky fault when any window sum leaves +/-threshold.
// Revision : 1.0 - initial generic-channel release with chunk ring buffer
// ============================================================================
module threshold_window_integrator #(
  parameter  int CHANNELS   = 8,
  parameter  int DATA_WIDTH = 16,
  parameter  int CHUNK_LOG2 = 4,
  parameter  int DEPTH      = 64,
  localparam int SUM_WIDTH  = DATA_WIDTH + CHUNK_LOG2 + $clog2(DEPTH) + 1,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           enable,
  input  logic                           clear,
  input  logic [CW-1:0]                  window_chunks,
  input  logic [SUM_WIDTH-2:0]           threshold,
  input  logic [CHANNELS*DATA_WIDTH-1:0] value_in,
  input  logic                           value_valid,
  output logic                           running,
  output logic                           window_full,
  output logic                           over_threshold,
  output logic [CHANNELS-1:0]            fault_mask,
  output logic                           config_error
);

  localparam int ACC_W = DATA_WIDTH + CHUNK_LOG2;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [1:0]     S_IDLE  = 2'd0;
  localparam logic [1:0]     S_RUN   = 2'd1;
  localparam logic [1:0]     S_FAULT = 2'd2;
  localparam logic [CHW-1:0] LAST_CH = CHW'(CHANNELS - 1);
  localparam logic [CW-1:0]  DEPTH_CW = CW'(DEPTH);

  // A pass must finish before the next chunk boundary can restage data.
  generate
    if (CHANNELS > (1 << CHUNK_LOG2)) begin : g_bad_channels
      $error("CHANNELS must not exceed 2**CHUNK_LOG2");
    end
  endgenerate

  logic [1:0]                  state_q, state_d;
  logic [CW-1:0]               win_q;
  logic [SUM_WIDTH-2:0]        thr_q;
  logic [CHUNK_LOG2-1:0]       samp_q;
  logic [PW-1:0]               wp_q;
  logic [CW-1:0]               cnt_q;
  logic                        pass_q;
  logic [CHW-1:0]              ch_q;
  logic                        wfull_q, over_q, cfg_q;
  logic [CHANNELS-1:0]         mask_q;

  logic signed [ACC_W-1:0]     acc_q  [CHANNELS];
  logic signed [ACC_W-1:0]     acc_d  [CHANNELS];
  logic signed [ACC_W-1:0]     stg_q  [CHANNELS];
  logic signed [ACC_W-1:0]     ring_q [CHANNELS][DEPTH];
  logic signed [SUM_WIDTH-1:0] sum_q  [CHANNELS];

  logic                        w_cfg_bad, w_start, w_go, w_accept, w_bound;
  logic                        w_step, w_last, w_viol;
  logic signed [SUM_WIDTH-1:0] w_new_sum, w_thr;
  logic [PW-1:0]               w_wp_next;
  logic [CW-1:0]               w_cnt_next;

  // Convert each offset-binary sample to signed and add it to its chunk accumulator.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      acc_d[i] = acc_q[i] + ACC_W'($signed({~value_in[i*DATA_WIDTH + DATA_WIDTH - 1],
                                            value_in[i*DATA_WIDTH +: DATA_WIDTH - 1]}));
    end
  end

  // Control decode, sliding-sum update for the channel in the pass, and bound check.
  always_comb begin
    w_cfg_bad  = (window_chunks == '0) || (window_chunks > DEPTH_CW);
    w_start    = (state_q == S_IDLE) && enable;
    w_go       = (state_q == S_RUN) && enable;
    w_accept   = w_go && value_valid;
    w_bound    = w_accept && (&samp_q);
    w_step     = w_go && pass_q;
    w_last     = w_step && (ch_q == LAST_CH);
    // Ring entries start at zero, so the fill phase subtracts nothing.
    w_new_sum  = sum_q[ch_q] + SUM_WIDTH'(stg_q[ch_q]) - SUM_WIDTH'(ring_q[ch_q][wp_q]);
    w_thr      = $signed({1'b0, thr_q});
    w_viol     = w_step && ((w_new_sum > w_thr) || (w_new_sum < -w_thr));
    w_wp_next  = (CW'(wp_q) == (win_q - CW'(1))) ? '0 : wp_q + PW'(1);
    w_cnt_next = (cnt_q == DEPTH_CW) ? cnt_q : cnt_q + CW'(1);
  end

  // State transitions; a violating pass still runs to its last channel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = w_cfg_bad ? S_FAULT : S_RUN;
      S_RUN: begin
        if (!enable)                          state_d = S_IDLE;
        else if (w_last && (over_q || w_viol)) state_d = S_FAULT;
      end
      S_FAULT: if (clear) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers: configuration, counters, pass sequencing and status flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      thr_q   <= '0;
      samp_q  <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      ch_q    <= '0;
      wfull_q <= 1'b0;
      over_q  <= 1'b0;
      cfg_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            win_q  <= window_chunks;
            thr_q  <= threshold;
            samp_q <= '0;
            wp_q   <= '0;
            cnt_q  <= '0;
            pass_q <= 1'b0;
            ch_q   <= '0;
            if (w_cfg_bad) begin
              cfg_q  <= 1'b1;
              over_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!enable) begin
            pass_q  <= 1'b0;
            ch_q    <= '0;
            wfull_q <= 1'b0;
            over_q  <= 1'b0;
            mask_q  <= '0;
          end else begin
            if (w_accept) samp_q <= samp_q + CHUNK_LOG2'(1);
            if (w_step) begin
              if (w_viol) begin
                mask_q[ch_q] <= 1'b1;
                over_q       <= 1'b1;
              end
              if (w_last) begin
                pass_q <= 1'b0;
                ch_q   <= '0;
                wp_q   <= w_wp_next;
                cnt_q  <= w_cnt_next;
                if (w_cnt_next >= win_q) wfull_q <= 1'b1;
              end else begin
                ch_q <= ch_q + CHW'(1);
              end
            end
            // A boundary coinciding with the last pass step starts the next pass.
            if (w_bound) begin
              pass_q <= 1'b1;
              ch_q   <= '0;
            end
          end
        end
        S_FAULT: begin
          if (clear) begin
            wfull_q <= 1'b0;
            over_q  <= 1'b0;
            cfg_q   <= 1'b0;
            mask_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath storage: accumulators, staging, window sums and the chunk ring.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
        stg_q[i] <= '0;
        sum_q[i] <= '0;
        for (int d = 0; d < DEPTH; d++) ring_q[i][d] <= '0;
      end
    end else if (w_start) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
        stg_q[i] <= '0;
        sum_q[i] <= '0;
        for (int d = 0; d < DEPTH; d++) ring_q[i][d] <= '0;
      end
    end else begin
      if (w_accept) begin
        for (int i = 0; i < CHANNELS; i++) acc_q[i] <= w_bound ? '0 : acc_d[i];
      end
      if (w_bound) begin
        for (int i = 0; i < CHANNELS; i++) stg_q[i] <= acc_d[i];
      end
      if (w_step) begin
        sum_q[ch_q]        <= w_new_sum;
        ring_q[ch_q][wp_q] <= stg_q[ch_q];
      end
    end
  end

  assign running        = (state_q == S_RUN);
  assign window_full    = wfull_q;
  assign over_threshold = over_q;
  assign fault_mask     = mask_q;
  assign config_error   = cfg_q;

endmodule
`default_nettype wire

// File: tb/tb_threshold_window_integrator.sv
`default_nettype none
// ============================================================================
// Module   : tb_threshold_window_integrator
// Purpose  : Scoreboard bench for threshold_window_integrator (4 ch, 4-sample
//            chunks, depth 8) with directed vectors and hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_threshold_window_integrator;
  localparam int CH  = 4;
  localparam int DW  = 16;
  localparam int CL  = 2;
  localparam int DP  = 8;
  localparam int SW  = DW + CL + $clog2(DP) + 1;
  localparam int CWT = $clog2(DP + 1);

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic              value_valid = 1'b0;
  logic [CWT-1:0]    window_chunks = '0;
  logic [SW-2:0]     threshold = '0;
  logic [CH*DW-1:0]  value_in = '0;
  logic              running, window_full, over_threshold, config_error;
  logic [CH-1:0]     fault_mask;

  threshold_window_integrator #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .CHUNK_LOG2(CL), .DEPTH(DP)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
    .window_chunks(window_chunks), .threshold(threshold),
    .value_in(value_in), .value_valid(value_valid),
    .running(running), .window_full(window_full),
    .over_threshold(over_threshold), .fault_mask(fault_mask),
    .config_error(config_error)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n it holds n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string         name;
    bit            run;
    bit            wf;
    bit            ovr;
    logic [CH-1:0] mask;
    bit            cfg;
  } snap_t;

  typedef struct {
    string         name;
    logic [CH-1:0] mask;
    int            cyc;
  } fault_t;

  snap_t  exp_q[$];
  fault_t fexp_q[$];
  snap_t  e;
  fault_t f;
  int     snap_req = 0;
  int     snap_done = 0;
  int     tests = 0;
  int     failures = 0;
  logic   prev_over = 1'b0;

  // Monitor: pops expected status snapshots on request and expected faults on
  // every rising edge of over_threshold.
  always @(negedge clk) begin
    if (snap_req != snap_done) begin
      e = exp_q.pop_front();
      tests++;
      if (running !== e.run || window_full !== e.wf || over_threshold !== e.ovr ||
          fault_mask !== e.mask || config_error !== e.cfg) begin
        failures++;
        $display("FAIL %s: got run=%0b wf=%0b ovr=%0b mask=%b cfg=%0b, want run=%0b wf=%0b ovr=%0b mask=%b cfg=%0b",
                 e.name, running, window_full, over_threshold, fault_mask, config_error,
                 e.run, e.wf, e.ovr, e.mask, e.cfg);
      end
      snap_done++;
    end
    if (over_threshold === 1'b1 && prev_over === 1'b0) begin
      tests++;
      if (fexp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_fault: got over_threshold=1 mask=%b at edge %0d, want no fault",
                 fault_mask, cyc);
      end else begin
        f = fexp_q.pop_front();
        if (fault_mask !== f.mask || cyc != f.cyc) begin
          failures++;
          $display("FAIL %s: got mask=%b at edge %0d, want mask=%b at edge %0d",
                   f.name, fault_mask, cyc, f.mask, f.cyc);
        end
      end
    end
    prev_over = over_threshold;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    value_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drive(input logic [CH*DW-1:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      value_in    = v;
      value_valid = 1'b1;
      tick();
    end
    value_valid = 1'b0;
  endtask

  task automatic start(input logic [CWT-1:0] w, input logic [SW-2:0] t);
    window_chunks = w;
    threshold     = t;
    enable        = 1'b1;
    tick();
  endtask

  task automatic stop();
    enable = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    enable = 1'b0;
    clear  = 1'b1;
    tick();
    clear  = 1'b0;
  endtask

  // Expect over_threshold to rise 'lat' edges after the next edge.
  task automatic expect_fault(input string name, input logic [CH-1:0] mask, input int lat);
    fault_t x;
    x.name = name;
    x.mask = mask;
    x.cyc  = cyc + 1 + lat;
    fexp_q.push_back(x);
  endtask

  task automatic check(input string name, input bit run, input bit wf, input bit ovr,
                       input logic [CH-1:0] mask, input bit cfg);
    snap_t x;
    x.name = name; x.run = run; x.wf = wf; x.ovr = ovr; x.mask = mask; x.cfg = cfg;
    exp_q.push_back(x);
    snap_req++;
    for (int k = 0; k < 10 && snap_done != snap_req; k++) begin
      @(negedge clk);
      #1;
    end
    if (snap_done != snap_req) begin
      tests++;
      failures++;
      $display("FAIL %s_timeout: got no snapshot, want one", name);
    end
  endtask

  function automatic logic [CH*DW-1:0] mk(input logic [DW-1:0] c3, input logic [DW-1:0] c2,
                                          input logic [DW-1:0] c1, input logic [DW-1:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH*DW-1:0] zero_v, v;
    zero_v = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000);

    // Reset and quiet idle
    repeat (3) tick();
    check("reset", 0, 0, 0, 4'b0000, 0);
    resetn = 1'b1;
    idle(4);
    check("idle_no_enable", 0, 0, 0, 4'b0000, 0);

    // Zero input, threshold 0: never faults, window fills after 4 chunks
    start(4'd4, '0);
    check("start_running", 1, 0, 0, 4'b0000, 0);
    drive(zero_v, 15);
    check("zero_before_full", 1, 0, 0, 4'b0000, 0);
    drive(zero_v, 985);
    idle(6);
    check("zero_1000", 1, 1, 0, 4'b0000, 0);
    stop();

    // Channel 2 at +1, threshold 15: 4th chunk sum 16 faults at T+3
    v = mk(16'h8000, 16'h8001, 16'h8000, 16'h8000);
    start(4'd4, 21'd15);
    drive(v, 15);
    expect_fault("fault_ch2", 4'b0100, 3);
    drive(v, 1);
    idle(6);
    check("fault_ch2_state", 0, 1, 1, 4'b0100, 0);
    do_clear();
    check("clear_after_ch2", 0, 0, 0, 4'b0000, 0);

    // Same input, threshold 16: sum sits exactly at the bound, no fault
    start(4'd4, 21'd16);
    drive(v, 400);
    idle(6);
    check("thr16_no_fault", 1, 1, 0, 4'b0000, 0);
    stop();

    // Negative excursion: channel 0 at -2, sums -8,-16,-24 vs threshold 20
    v = mk(16'h8000, 16'h8000, 16'h8000, 16'h7FFE);
    start(4'd4, 21'd20);
    drive(v, 11);
    expect_fault("fault_ch0_neg", 4'b0001, 1);
    drive(v, 1);
    idle(6);
    check("fault_ch0_state", 0, 0, 1, 4'b0001, 0);
    do_clear();
    check("clear_after_ch0", 0, 0, 0, 4'b0000, 0);

    // Sliding subtraction: window 2, +40 holds sum at 320, then +60 chunk -> 400
    v = mk(16'h8000, 16'h8000, 16'h8028, 16'h8000);
    start(4'd2, 21'd350);
    drive(v, 80);
    idle(6);
    check("slide_hold_320", 1, 1, 0, 4'b0000, 0);
    v = mk(16'h8000, 16'h8000, 16'h803C, 16'h8000);
    drive(v, 3);
    expect_fault("fault_slide_ch1", 4'b0010, 2);
    drive(v, 1);
    idle(6);
    check("slide_fault_state", 0, 1, 1, 4'b0010, 0);

    // clear and enable together: clear wins, enable honoured next cycle
    window_chunks = 4'd2;
    threshold     = 21'd1000;
    enable        = 1'b1;
    clear         = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_wins", 0, 0, 0, 4'b0000, 0);
    tick();
    check("enable_after_clear", 1, 0, 0, 4'b0000, 0);
    stop();

    // Illegal window lengths
    expect_fault("cfg_zero_fault", 4'b0000, 0);
    start(4'd0, 21'd5);
    check("cfg_zero_state", 0, 0, 1, 4'b0000, 1);
    do_clear();
    check("cfg_zero_clear", 0, 0, 0, 4'b0000, 0);
    expect_fault("cfg_over_fault", 4'b0000, 0);
    start(4'd9, 21'd5);
    check("cfg_over_state", 0, 0, 1, 4'b0000, 1);
    do_clear();
    check("cfg_over_clear", 0, 0, 0, 4'b0000, 0);
    start(4'd2, 21'd1000);
    drive(zero_v, 8);
    idle(6);
    check("reenable_window2", 1, 1, 0, 4'b0000, 0);

    // Asynchronous reset in the middle of a pass
    drive(zero_v, 4);
    tick();
    resetn = 1'b0;
    enable = 1'b0;
    check("reset_midpass", 0, 0, 0, 4'b0000, 0);
    tick();
    resetn = 1'b1;
    idle(10);
    check("after_reset_quiet", 0, 0, 0, 4'b0000, 0);

    idle(2);
    tests++;
    if (fexp_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations: got %0d faults and %0d snapshots outstanding, want 0 and 0",
               fexp_q.size(), exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/threshold_window_integrator.md
# threshold_window_integrator

Parametrised sliding-window integrator that sums offset-binary samples from N channels over a runtime-selectable window. It raises a sticky fault when any channel's window sum leaves ±threshold. It sits between the ADC/DAC sample stream and the shutdown/interlock logic. It replaces the fixed 8-channel, 16-bit integrator with a generic channel count, sample width and window depth, plus a real per-channel chunk ring buffer.

## Interface
- CHANNELS, 8: number of channels; must be ≤ 2^CHUNK_LOG2 (elaboration-time check).
- DATA_WIDTH, 16: sample width, offset binary.
- CHUNK_LOG2, 4: samples per chunk = 2^CHUNK_LOG2.
- DEPTH, 64: maximum chunks per window (ring depth per channel).
- Derived widths: SUM_WIDTH = DATA_WIDTH + CHUNK_LOG2 + clog2(DEPTH) + 1. CW = clog2(DEPTH+1).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  level; rising use in IDLE latches configuration and starts integration.
- clear  in  1  pulse; leaves FAULT to IDLE.
- window_chunks  in  CW  window length in chunks, legal 1..DEPTH; sampled only in IDLE.
- threshold  in  SUM_WIDTH-1  unsigned bound on |window sum|; sampled only in IDLE.
- value_in  in  CHANNELS*DATA_WIDTH  channel i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- value_valid  in  1  one sample vector for all channels this cycle.
- running  out  1  high in RUNNING.
- window_full  out  1  high once window_chunks chunks have been integrated since start.
- over_threshold  out  1  sticky fault flag.
- fault_mask  out  CHANNELS  sticky per-channel violation bits.
- config_error  out  1  illegal window_chunks was latched.

## Operation
- States: IDLE, RUNNING, FAULT.
- IDLE, enable=1:
  - latch window_chunks and threshold;
  - zero all accumulators, ring entries, window sums and ring pointer;
  - if window_chunks is 0 or > DEPTH: config_error=1, over_threshold=1, fault_mask=0, go to FAULT;
  - else go to RUNNING.
- RUNNING, each value_valid:
  - each channel adds (value_in[i] XOR MSB), i.e. the signed value v−2^(DATA_WIDTH−1), into its chunk accumulator;
  - the sample counter increments.
- Chunk boundary (2^CHUNK_LOG2-th valid sample):
  - all accumulators, including that sample, are copied to staging registers, and the accumulators restart at zero the same cycle;
  - a sequential pass starts, one channel per cycle, i = 0..CHANNELS-1: sum[i] <= sum[i] + staged[i] − ring[i][wp], then ring[i][wp] <= staged[i];
  - entries not yet written are zero, so the fill phase needs no special case.
- After the pass:
  - wp advances and wraps at window_chunks−1;
  - the chunk count increments and saturates; window_full=1 once it reaches window_chunks.
- Check, evaluated on the new sum in the same cycle as its update: fault if new_sum > +threshold or new_sum < −threshold (strict, threshold zero-extended).
- On any violation:
  - set fault_mask[i] and over_threshold;
  - finish the current pass so every violating channel in that chunk is flagged;
  - then enter FAULT.
- FAULT:
  - ignore value_valid; hold all outputs;
  - clear → IDLE, clearing over_threshold, fault_mask, config_error and window_full.
- enable deasserted in RUNNING → IDLE at the next edge. Pass state is discarded, flags are cleared, and the next enable re-zeroes everything.
- Arithmetic: signed two's complement throughout. SUM_WIDTH cannot overflow, by construction.

## Timing
- Reset (resetn=0): state IDLE; running, window_full, over_threshold, config_error = 0; fault_mask = 0; all internal state zero. Reset is asynchronous to assert, and removal is synchronous to clk. Reset mid-pass aborts immediately.
- IDLE→RUNNING: running rises 1 cycle after enable is sampled high.
- Fault latency: the boundary sample is accepted at edge T, and channel i is updated at edge T+1+i. over_threshold and fault_mask[i] become visible after edge T+1+i. FAULT is entered at edge T+CHANNELS.
- value_valid may be asserted during a pass; the staging registers decouple it. The constraint CHANNELS ≤ 2^CHUNK_LOG2 guarantees a pass ends before the next boundary.
- clear and enable together in FAULT: clear wins, and the block goes to IDLE. enable is honoured on the following cycle.

## Test plan
- Reset: assert resetn=0 mid-pass → all outputs 0 and state IDLE within the same cycle; after release, no output changes without enable.
- CHANNELS=4, CHUNK_LOG2=2, window 4, threshold 0, all inputs 0x8000 for 1000 valid cycles → over_threshold stays 0; window_full=1 after the 16th sample.
- Same config, threshold 15, channel 2=0x8001, others 0x8000:
  - fault when the 4th chunk closes (sum 16) → over_threshold=1, fault_mask=0b0100, at edge T+3 after the boundary sample;
  - with threshold 16 instead → no fault after 100 chunks.
- Channel 0=0x7FFE (−2), window 4, threshold 20 → sums −8, −16, −24; fault at the 3rd chunk, fault_mask=0b0001.
- Sliding subtraction, window 2, threshold 350, channel 1=0x8028 (+40) for 20 chunks → sum holds at 320, no fault; then one chunk at 0x803C (+60) → sum 400, fault.
- window_chunks=0 → config_error=1, over_threshold=1, fault_mask=0, state FAULT. Then clear → all flags 0; re-enable with window 2 runs normally.
